// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared types and helpers for the uart_tx_arbiter slice        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam int STATE_W = 5;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 5'b00001,
        ST_ACCEPT    = 5'b00010,
        ST_START     = 5'b00100,
        ST_WAIT_BUSY = 5'b01000,
        ST_WAIT_DONE = 5'b10000
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index width, never zero so a 1-requester build still has a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester bundle plus uart_tx start/ready handshake |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic               timeout_err;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, grant, tx_start, tx_data, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, grant, tx_start, tx_data, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, first valid at/after pointer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // pointer < N_REQ, so one conditional subtract is enough to wrap.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, pointer} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any_valid && req_valid[cand]) begin
                any_valid        = 1'b1;
                winner_idx       = cand;
                winner_oh[cand]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin, packet-locked sharing of one uart_tx      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    uart_tx_arbiter_if.slave   bus
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(N_REQ - 1);

    state_t           state_q,     state_d;
    logic [N_REQ-1:0] grant_q,     grant_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic             tx_start_q,  tx_start_d;
    logic [7:0]       tx_data_q,   tx_data_d;
    logic             last_q,      last_d;
    logic             err_q,       err_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [IDX_W-1:0] owner_q,     owner_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [N_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_release;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_valid  (bus.req_valid),
        .pointer    (ptr_q),
        .winner_oh  (w_pick_oh),
        .winner_idx (w_pick_idx),
        .any_valid  (w_pick_any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        err_d       = err_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        w_release   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (w_pick_any && bus.tx_ready) begin
                    grant_d = w_pick_oh;
                    owner_d = w_pick_idx;
                    state_d = ST_ACCEPT;
                end
            end
            // Owner keeps the lock here for as long as it withholds its next byte.
            ST_ACCEPT: begin
                if (bus.req_valid[owner_q]) begin
                    tx_data_d            = bus.req_data[{owner_q, 3'b000} +: 8];
                    last_d               = bus.req_last[owner_q];
                    req_ready_d[owner_q] = 1'b1;
                    state_d              = ST_START;
                end
            end
            ST_START: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end
            // A transmitter that never acknowledges must not wedge the arbiter.
            ST_WAIT_BUSY: begin
                if (!bus.tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == C_CNT_LAST) begin
                    err_d     = 1'b1;
                    w_release = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_ready) begin
                    w_release = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (w_release) begin
            if (last_q) begin
                ptr_d   = (owner_q == C_IDX_LAST) ? '0 : owner_q + IDX_W'(1);
                grant_d = '0;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_ACCEPT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            last_q      <= last_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.req_ready   = req_ready_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed + randomized bench with packet-level model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ       (N),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic uart_rdy   = 1'b1;
    logic hold_busy  = 1'b0;
    logic uart_stuck = 1'b0;
    assign bus.tx_ready = uart_rdy & ~hold_busy;

    // dq_*: what each requester still presents; mq_*: packets not yet scheduled by the model
    byte unsigned dq_data [N][$];
    bit           dq_last [N][$];
    byte unsigned mq_data [N][$];
    bit           mq_last [N][$];
    byte unsigned exp_data[$];
    int           exp_owner[$];
    int           model_ptr = 0;
    byte unsigned uart_held;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_packet(input int r, input int len, input int base);
        byte unsigned d;
        for (int b = 0; b < len; b++) begin
            d = (base < 0) ? 8'($urandom) : 8'(base + b);
            dq_data[r].push_back(d);
            dq_last[r].push_back(b == len - 1);
            mq_data[r].push_back(d);
            mq_last[r].push_back(b == len - 1);
        end
    endtask

    // Whole packets are served one at a time, owners picked round-robin from model_ptr.
    task automatic model_schedule();
        int win;
        int c;
        bit l;
        for (int guard = 0; guard < 256; guard++) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                c = (model_ptr + k) % N;
                if (win < 0 && mq_data[c].size() > 0) win = c;
            end
            if (win < 0) break;
            l = 1'b0;
            while (!l && mq_data[win].size() > 0) begin
                exp_data.push_back(mq_data[win].pop_front());
                exp_owner.push_back(win);
                l = mq_last[win].pop_front();
            end
            model_ptr = (win + 1) % N;
        end
    endtask

    function automatic int dq_total();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += dq_data[i].size();
        return s;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((exp_data.size() > 0 || bus.grant !== '0 || dq_total() > 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_pending_bytes"}, 32'(exp_data.size()), 32'd0);
        chk({tag, "_grant_released"}, 32'(bus.grant), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            dq_data[i].delete();
            dq_last[i].delete();
            mq_data[i].delete();
            mq_last[i].delete();
        end
        exp_data.delete();
        exp_owner.delete();
    endtask

    // Requester drivers: present queue head, consume it on the req_ready pulse
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] === 1'b1 && dq_data[i].size() > 0) begin
                    void'(dq_data[i].pop_front());
                    void'(dq_last[i].pop_front());
                end
                if (dq_data[i].size() > 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[i*8 +: 8] = dq_data[i][0];
                    bus.req_last[i]        = dq_last[i][0];
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[i*8 +: 8] = 8'h00;
                    bus.req_last[i]        = 1'b0;
                end
            end
        end
    end

    // uart_tx model: random ack delay and busy time, unless stuck
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && bus.tx_start === 1'b1 && !uart_stuck) begin
                uart_held = bus.tx_data;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                uart_rdy = 1'b0;
                repeat ($urandom_range(3, 6)) @(negedge clk);
                if (rstn === 1'b1) chk("tx_data_stable", 32'(bus.tx_data), 32'(uart_held));
                uart_rdy = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (bus.req_ready !== '0) begin
                    if (exp_owner.size() > 0)
                        chk("req_ready_owner", 32'(bus.req_ready), 32'd1 << exp_owner[0]);
                    else
                        chk("req_ready_unexpected", 32'(bus.req_ready), 32'd0);
                end
                if (bus.tx_start === 1'b1) begin
                    if (exp_data.size() > 0) begin
                        chk("tx_data_order", 32'(bus.tx_data), 32'(exp_data[0]));
                        chk("tx_grant_owner", 32'(bus.grant), 32'd1 << exp_owner[0]);
                        void'(exp_data.pop_front());
                        void'(exp_owner.pop_front());
                    end else begin
                        chk("tx_start_unexpected", 32'(bus.tx_start), 32'd0);
                    end
                end
                if (bus.grant !== prev_grant && prev_grant != '0 && bus.grant != '0)
                    chk("grant_via_idle", 32'(bus.grant), 32'd0);
                prev_grant = bus.grant;
            end else begin
                prev_grant = '0;
            end
        end
    end

    initial begin
        int t;
        int np;

        // Reset values
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant",     32'(bus.grant),       32'd0);
        chk("rst_req_ready", 32'(bus.req_ready),   32'd0);
        chk("rst_tx_start",  32'(bus.tx_start),    32'd0);
        chk("rst_tx_data",   32'(bus.tx_data),     32'd0);
        chk("rst_err",       32'(bus.timeout_err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // All four requesters, single-byte packets
        for (int r = 0; r < N; r++) add_packet(r, 1, 8'hA0 + r);
        model_schedule();
        wait_drain("all4", 300);

        // req0 three-byte packet, with the latency profile checked cycle by cycle
        add_packet(0, 3, 8'h41);
        model_schedule();
        @(negedge clk);
        chk("lat_grant_c0",     32'(bus.grant),     32'd0);
        @(negedge clk);
        chk("lat_grant_c1",     32'(bus.grant),     32'b0001);
        chk("lat_ready_c1",     32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("lat_ready_c2",     32'(bus.req_ready), 32'b0001);
        chk("lat_start_c2",     32'(bus.tx_start),  32'd0);
        @(negedge clk);
        chk("lat_start_c3",     32'(bus.tx_start),  32'd1);
        wait_drain("req0_pkt", 300);

        // Pointer now past req0: req1 must win over req0
        add_packet(0, 1, 8'h10);
        add_packet(1, 1, 8'h11);
        model_schedule();
        wait_drain("ptr_adv", 300);

        // req2 locked mid-packet while req1 arrives
        add_packet(2, 3, 8'h60);
        model_schedule();
        t = 0;
        while (bus.req_ready[2] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        chk("lock_first_accept", 32'(bus.req_ready), 32'b0100);
        add_packet(1, 1, 8'h70);
        model_schedule();
        wait_drain("lock", 400);

        // tx_ready low in IDLE blocks the grant
        hold_busy = 1'b1;
        add_packet(2, 1, 8'h5A);
        model_schedule();
        repeat (6) @(negedge clk);
        chk("busy_no_grant", 32'(bus.grant), 32'd0);
        hold_busy = 1'b0;
        @(negedge clk);
        chk("busy_then_grant", 32'(bus.grant), 32'b0100);
        wait_drain("busy", 300);

        // Randomized packet mixes
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < N; r++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) add_packet(r, $urandom_range(1, 3), -1);
            end
            model_schedule();
            wait_drain("random", 3000);
        end

        // Stuck transmitter: timeout after TO cycles in WAIT_BUSY, then carry on
        uart_stuck = 1'b1;
        add_packet(1, 2, -1);
        model_schedule();
        t = 0;
        while (bus.tx_start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        chk("to_start_seen", 32'(bus.tx_start), 32'd1);
        repeat (TO - 1) @(negedge clk);
        chk("to_err_before", 32'(bus.timeout_err), 32'd0);
        @(negedge clk);
        chk("to_err_set", 32'(bus.timeout_err), 32'd1);
        wait_drain("timeout", 300);
        chk("to_err_sticky1", 32'(bus.timeout_err), 32'd1);
        uart_stuck = 1'b0;
        add_packet(3, 1, -1);
        model_schedule();
        wait_drain("after_to", 300);
        chk("to_err_sticky2", 32'(bus.timeout_err), 32'd1);

        // Asynchronous reset during WAIT_DONE
        add_packet(3, 2, -1);
        model_schedule();
        t = 0;
        while (bus.tx_ready !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        chk("rr_busy_seen", 32'(bus.tx_ready), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_grant",     32'(bus.grant),       32'd0);
        chk("arst_tx_start",  32'(bus.tx_start),    32'd0);
        chk("arst_req_ready", 32'(bus.req_ready),   32'd0);
        chk("arst_tx_data",   32'(bus.tx_data),     32'd0);
        chk("arst_err",       32'(bus.timeout_err), 32'd0);
        clear_all();
        model_ptr = 0;
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        add_packet(2, 1, 8'h22);
        add_packet(3, 1, 8'h33);
        model_schedule();
        wait_drain("post_rst", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
